// File: rtl/id_stage_pkg.sv
// Shared instruction encodings: opcodes, funct codes, forwarding selects and
// the decoded instruction classes used by the decode stage.
package id_stage_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0a;
  localparam logic [5:0] OpSltiu   = 6'h0b;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2b;

  // REGIMM sub-opcodes live in the rt field.
  localparam logic [4:0] RtBltz = 5'h00;
  localparam logic [4:0] RtBgez = 5'h01;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;

  localparam logic [1:0] FwdGrf    = 2'd0;
  localparam logic [1:0] FwdE      = 2'd1;
  localparam logic [1:0] FwdM      = 2'd2;
  localparam logic [1:0] FwdGrfAlt = 2'd3;

  localparam int unsigned InstrClassW = 4;

  typedef enum logic [InstrClassW-1:0] {
    ClsOther,
    ClsBeq,
    ClsBne,
    ClsBlez,
    ClsBgtz,
    ClsBltz,
    ClsBgez,
    ClsZext,
    ClsLui
  } instr_class_e;

  function automatic instr_class_e decode_class(input logic [5:0] opcode, input logic [4:0] rt);
    instr_class_e cls;
    cls = ClsOther;
    case (opcode)
      OpBeq:  cls = ClsBeq;
      OpBne:  cls = ClsBne;
      OpBlez: cls = ClsBlez;
      OpBgtz: cls = ClsBgtz;
      OpRegimm: begin
        if (rt == RtBltz) cls = ClsBltz;
        else if (rt == RtBgez) cls = ClsBgez;
      end
      OpAndi, OpOri, OpXori: cls = ClsZext;
      OpLui:  cls = ClsLui;
      default: cls = ClsOther;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/id_stage_grf.sv
// 32x32 general register file with write-to-read bypass.
// Define GRF_DISPLAY_EN to trace every committed write.
module id_stage_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc
);

  logic [31:0] regs_q [32];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
`ifdef GRF_DISPLAY_EN
      $display("@%h: $%0d <= %h", pc, waddr, wdata);
`endif
    end
  end

`ifndef GRF_DISPLAY_EN
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == 5'd0) rdata1 = 32'd0;
    else if (wr_en && (waddr == raddr1)) rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == 5'd0) rdata2 = 32'd0;
    else if (wr_en && (waddr == raddr2)) rdata2 = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: register read with forwarding, branch compare, immediate
// extension and the ID/EX pipeline register. Trace option: GRF_DISPLAY_EN.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        clr,
  input  logic [31:0] code_ID,
  input  logic [31:0] PC_ID,
  input  logic        we_W,
  input  logic [4:0]  waddr_W,
  input  logic [31:0] wdata_W,
  input  logic [31:0] PC_W,
  input  logic [1:0]  fwdSelRs,
  input  logic [1:0]  fwdSelRt,
  input  logic [31:0] fwdData_E,
  input  logic [31:0] fwdData_M,
  output logic [4:0]  rs_ID,
  output logic [4:0]  rt_ID,
  output logic        cmp,
  output logic [15:0] imm16,
  output logic [25:0] jmpAddr,
  output logic [31:0] jmpReg,
  output logic [31:0] code_EX,
  output logic [31:0] PC_EX,
  output logic [31:0] rsData_EX,
  output logic [31:0] rtData_EX,
  output logic [31:0] ext32_EX
);

  logic [31:0]  rs_grf, rt_grf;
  logic [31:0]  rs_val, rt_val;
  logic [31:0]  ext32;
  instr_class_e cls;

  logic [31:0] code_ex_q, pc_ex_q, rs_ex_q, rt_ex_q, ext_ex_q;

  assign rs_ID   = code_ID[25:21];
  assign rt_ID   = code_ID[20:16];
  assign imm16   = code_ID[15:0];
  assign jmpAddr = code_ID[25:0];

  id_stage_grf u_grf (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs_ID),
    .raddr2 (rt_ID),
    .rdata1 (rs_grf),
    .rdata2 (rt_grf),
    .we     (we_W),
    .waddr  (waddr_W),
    .wdata  (wdata_W),
    .pc     (PC_W)
  );

  // $0 is hard zero even when a forwarding select points elsewhere.
  always_comb begin
    case (fwdSelRs)
      FwdE:    rs_val = fwdData_E;
      FwdM:    rs_val = fwdData_M;
      default: rs_val = rs_grf;
    endcase
    if (rs_ID == 5'd0) rs_val = 32'd0;
  end

  always_comb begin
    case (fwdSelRt)
      FwdE:    rt_val = fwdData_E;
      FwdM:    rt_val = fwdData_M;
      default: rt_val = rt_grf;
    endcase
    if (rt_ID == 5'd0) rt_val = 32'd0;
  end

  assign jmpReg = rs_val;
  assign cls    = decode_class(code_ID[31:26], code_ID[20:16]);

  always_comb begin
    case (cls)
      ClsBeq:  cmp = (rs_val == rt_val);
      ClsBne:  cmp = (rs_val != rt_val);
      ClsBlez: cmp = rs_val[31] || (rs_val == 32'd0);
      ClsBgtz: cmp = !rs_val[31] && (rs_val != 32'd0);
      ClsBltz: cmp = rs_val[31];
      ClsBgez: cmp = !rs_val[31];
      default: cmp = 1'b0;
    endcase
  end

  always_comb begin
    case (cls)
      ClsZext: ext32 = {16'd0, imm16};
      ClsLui:  ext32 = {imm16, 16'd0};
      default: ext32 = {{16{imm16[15]}}, imm16};
    endcase
  end

  // clr shares priority with reset so a flush always beats a stall.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      code_ex_q <= 32'd0;
      pc_ex_q   <= 32'd0;
      rs_ex_q   <= 32'd0;
      rt_ex_q   <= 32'd0;
      ext_ex_q  <= 32'd0;
    end else if (!stall) begin
      code_ex_q <= code_ID;
      pc_ex_q   <= PC_ID;
      rs_ex_q   <= rs_val;
      rt_ex_q   <= rt_val;
      ext_ex_q  <= ext32;
    end
  end

  assign code_EX   = code_ex_q;
  assign PC_EX     = pc_ex_q;
  assign rsData_EX = rs_ex_q;
  assign rtData_EX = rt_ex_q;
  assign ext32_EX  = ext_ex_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: combinational decode checks plus a scoreboard
// of expected ID/EX contents popped one cycle after each load.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, stall, clr;
  logic [31:0] code_ID, PC_ID;
  logic        we_W;
  logic [4:0]  waddr_W;
  logic [31:0] wdata_W, PC_W;
  logic [1:0]  fwdSelRs, fwdSelRt;
  logic [31:0] fwdData_E, fwdData_M;
  logic [4:0]  rs_ID, rt_ID;
  logic        cmp;
  logic [15:0] imm16;
  logic [25:0] jmpAddr;
  logic [31:0] jmpReg;
  logic [31:0] code_EX, PC_EX, rsData_EX, rtData_EX, ext32_EX;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ext;
  } ex_t;

  ex_t         sb[$];
  logic [31:0] model[32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .clr       (clr),
    .code_ID   (code_ID),
    .PC_ID     (PC_ID),
    .we_W      (we_W),
    .waddr_W   (waddr_W),
    .wdata_W   (wdata_W),
    .PC_W      (PC_W),
    .fwdSelRs  (fwdSelRs),
    .fwdSelRt  (fwdSelRt),
    .fwdData_E (fwdData_E),
    .fwdData_M (fwdData_M),
    .rs_ID     (rs_ID),
    .rt_ID     (rt_ID),
    .cmp       (cmp),
    .imm16     (imm16),
    .jmpAddr   (jmpAddr),
    .jmpReg    (jmpReg),
    .code_EX   (code_EX),
    .PC_EX     (PC_EX),
    .rsData_EX (rsData_EX),
    .rtData_EX (rtData_EX),
    .ext32_EX  (ext32_EX)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] p, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] e);
    ex_t x;
    x.code = c; x.pc = p; x.rs = rs; x.rt = rt; x.ext = e;
    sb.push_back(x);
  endtask

  // Advance one cycle; any expectation queued for this edge is compared.
  task automatic tick();
    ex_t x;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      check("code_EX", code_EX, x.code);
      check("PC_EX", PC_EX, x.pc);
      check("rsData_EX", rsData_EX, x.rs);
      check("rtData_EX", rtData_EX, x.rt);
      check("ext32_EX", ext32_EX, x.ext);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_W = 1'b1; waddr_W = a; wdata_W = d; PC_W = 32'h0040_0000 + {27'd0, a};
    tick();
    we_W = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  logic [31:0] c;

  initial begin
    reset = 1'b1; stall = 1'b0; clr = 1'b0;
    code_ID = 32'd0; PC_ID = 32'd0;
    we_W = 1'b0; waddr_W = 5'd0; wdata_W = 32'd0; PC_W = 32'd0;
    fwdSelRs = 2'd0; fwdSelRt = 2'd0; fwdData_E = 32'd0; fwdData_M = 32'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    push(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    wr(5'd1, 32'd7);
    wr(5'd2, 32'd5);

    // Bypass: write $8 while decoding addu $9,$8,$0.
    c = {6'h00, 5'd8, 5'd0, 5'd9, 5'd0, 6'h21};
    code_ID = c; PC_ID = 32'h100;
    we_W = 1'b1; waddr_W = 5'd8; wdata_W = 32'h1234;
    #1;
    check("bypass_jmpReg", jmpReg, 32'h1234);
    check("rs_ID", {27'd0, rs_ID}, 32'd8);
    check("imm16", {16'd0, imm16}, 32'h4821);
    push(c, 32'h100, 32'h1234, 32'd0, 32'h0000_4821);
    tick();
    we_W = 1'b0; model[8] = 32'h1234;
    #1;
    check("grf_read_8", jmpReg, model[8]);

    // $0 ignores writes and forwarding.
    code_ID = {6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h21};
    we_W = 1'b1; waddr_W = 5'd0; wdata_W = 32'hFFFF;
    #1;
    check("r0_bypass", jmpReg, 32'd0);
    tick();
    we_W = 1'b0;
    fwdSelRs = 2'd1; fwdData_E = 32'hDEAD;
    #1;
    check("r0_fwd", jmpReg, 32'd0);
    fwdSelRs = 2'd0;

    // beq $1,$2 with rt forwarded.
    c = {6'h04, 5'd1, 5'd2, 16'h0010};
    code_ID = c; PC_ID = 32'h104;
    fwdSelRt = 2'd1; fwdData_E = 32'd7;
    #1;
    check("beq_fwdE_eq", {31'd0, cmp}, 32'd1);
    fwdData_E = 32'd8;
    #1;
    check("beq_fwdE_ne", {31'd0, cmp}, 32'd0);
    fwdSelRt = 2'd2; fwdData_M = 32'd7;
    #1;
    check("beq_fwdM_eq", {31'd0, cmp}, 32'd1);
    fwdSelRt = 2'd3;
    #1;
    check("beq_grf", {31'd0, cmp}, 32'd0);
    push(c, 32'h104, model[1], model[2], 32'h0000_0010);
    tick();
    fwdSelRt = 2'd0;

    c = {6'h05, 5'd1, 5'd2, 16'h0004};
    code_ID = c;
    #1;
    check("bne", {31'd0, cmp}, 32'd1);
    check("jmpAddr", {6'd0, jmpAddr}, {6'd0, c[25:0]});

    // Signed branches on a forwarded 0x80000000.
    fwdSelRs = 2'd2; fwdData_M = 32'h8000_0000;
    c = {6'h01, 5'd3, 5'd0, 16'hFFFC};
    code_ID = c; PC_ID = 32'h108;
    #1;
    check("bltz_neg", {31'd0, cmp}, 32'd1);
    push(c, 32'h108, 32'h8000_0000, 32'd0, 32'hFFFF_FFFC);
    tick();
    code_ID = {6'h07, 5'd3, 5'd0, 16'h0008};
    #1;
    check("bgtz_neg", {31'd0, cmp}, 32'd0);
    code_ID = {6'h06, 5'd3, 5'd0, 16'h0008};
    #1;
    check("blez_neg", {31'd0, cmp}, 32'd1);
    code_ID = {6'h01, 5'd3, 5'd1, 16'h0008};
    #1;
    check("bgez_neg", {31'd0, cmp}, 32'd0);
    fwdSelRs = 2'd0;
    code_ID = {6'h07, 5'd1, 5'd0, 16'h0008};
    #1;
    check("bgtz_pos", {31'd0, cmp}, 32'd1);

    // Extension.
    c = {6'h0d, 5'd1, 5'd4, 16'h8000};
    code_ID = c; PC_ID = 32'h10c;
    #1;
    check("ori_cmp", {31'd0, cmp}, 32'd0);
    push(c, 32'h10c, model[1], model[4], 32'h0000_8000);
    tick();
    c = {6'h0f, 5'd0, 5'd4, 16'h8000};
    code_ID = c; PC_ID = 32'h200;
    push(c, 32'h200, 32'd0, model[4], 32'h8000_0000);
    tick();

    // Stall holds the lui; clr beats stall.
    stall = 1'b1;
    code_ID = {6'h0d, 5'd1, 5'd4, 16'h1111}; PC_ID = 32'h204;
    push(c, 32'h200, 32'd0, model[4], 32'h8000_0000);
    tick();
    push(c, 32'h200, 32'd0, model[4], 32'h8000_0000);
    tick();
    clr = 1'b1;
    push(0, 0, 0, 0, 0);
    tick();
    clr = 1'b0; stall = 1'b0;

    // Mid-run reset with a concurrent write to $5.
    c = {6'h0d, 5'd1, 5'd4, 16'h8000};
    code_ID = c; PC_ID = 32'h300;
    push(c, 32'h300, model[1], model[4], 32'h0000_8000);
    tick();
    reset = 1'b1; we_W = 1'b1; waddr_W = 5'd5; wdata_W = 32'hAAAA;
    push(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0; we_W = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    code_ID = {6'h00, 5'd5, 5'd1, 5'd9, 5'd0, 6'h21};
    #1;
    check("r5_after_reset", jmpReg, 32'd0);
    code_ID = {6'h00, 5'd1, 5'd8, 5'd9, 5'd0, 6'h21};
    PC_ID = 32'h304;
    #1;
    check("r1_after_reset", jmpReg, model[1]);
    push(code_ID, 32'h304, model[1], model[8], 32'h0000_4821);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
